// File: rtl/regfile_read_port.sv
// Register bank with one write strobe and one registered, handshaked read port; all state moves on negedge clk.
// Optional macro R0_BASE_ZERO_EN: a read of register 0 qualified by ba_out returns zero.
module regfile_read_port #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_gnt,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready,
  input  logic             ba_out
);

  // Handshake: a request is accepted (rd_gnt) when no result is held or the held one is
  // consumed on the same edge; a held result stays frozen until rd_ready=1 while rd_valid=1.
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mem [NUM_REGS];
  logic [WIDTH-1:0] rd_val;

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_gnt) state_nxt = HOLD;
      HOLD:    if (rd_ready && !rd_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_valid = 1'b0;
    rd_gnt   = 1'b0;
    rd_valid = (state == HOLD);
    rd_gnt   = clr & rd_req & (~rd_valid | rd_ready);
  end

  // Same-edge write to the requested register is forwarded to the reader.
  always_comb begin
    rd_val = mem[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) rd_val = wr_data;
`ifdef R0_BASE_ZERO_EN
    if (ba_out && (rd_addr == '0)) rd_val = '0;
`endif
  end

`ifndef R0_BASE_ZERO_EN
  logic unused_ba;
  assign unused_ba = ba_out;
`endif

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_gnt) rd_data <= rd_val;
    end
  end

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port: reset, basic read, backpressure, bypass, streaming, r0 qualifier.
module tb_regfile_read_port;

  logic        clk;
  logic        clr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_req;
  logic [3:0]  rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_ready;
  logic        ba_out;

  int n_checks;
  int n_fail;

  regfile_read_port #(.WIDTH(32), .NUM_REGS(16)) dut (
    .clk      (clk),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .ba_out   (ba_out)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the active negedge
  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_rd(input logic req, input logic [3:0] addr, input logic rdy);
    rd_req   = req;
    rd_addr  = addr;
    rd_ready = rdy;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data);
    drive_rd(1'b0, 4'd0, 1'b1);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    cycle();
    wr_en = 1'b0;
  endtask

  logic [31:0] exp_r0_ba;
  logic [31:0] exp_r0_byp;

  initial begin
    n_checks = 0;
    n_fail   = 0;
`ifdef R0_BASE_ZERO_EN
    exp_r0_ba  = 32'h0000_0000;
    exp_r0_byp = 32'h0000_0000;
`else
    exp_r0_ba  = 32'h0000_0040;
    exp_r0_byp = 32'h0000_0077;
`endif
    clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b1; rd_addr = '0; rd_ready = 1'b1; ba_out = 1'b0;

    // Reset state, with a request asserted during reset
    #3;
    check("reset_gnt", 32'(rd_gnt), 32'd0);
    check("reset_valid", 32'(rd_valid), 32'd0);
    check("reset_data", rd_data, 32'h0);
    cycle();
    cycle();
    check("reset_hold_valid", 32'(rd_valid), 32'd0);
    clr = 1'b1;
    rd_req = 1'b0;

    // Mid-handshake reset discards the held result and the stored words
    do_write(4'd5, 32'hDEAD_BEEF);
    do_write(4'd2, 32'h2222_2222);
    drive_rd(1'b1, 4'd2, 1'b0);
    cycle();
    check("pre_rst_valid", 32'(rd_valid), 32'd1);
    check("pre_rst_data", rd_data, 32'h2222_2222);
    #2;
    clr = 1'b0;
    #1;
    check("midrst_valid", 32'(rd_valid), 32'd0);
    check("midrst_data", rd_data, 32'h0);
    check("midrst_gnt", 32'(rd_gnt), 32'd0);
    #1;
    clr = 1'b1;
    drive_rd(1'b0, 4'd0, 1'b1);
    cycle();
    drive_rd(1'b1, 4'd5, 1'b1);
    #1;
    check("r5_gnt", 32'(rd_gnt), 32'd1);
    cycle();
    check("r5_after_rst", rd_data, 32'h0);
    check("r5_valid", 32'(rd_valid), 32'd1);

    // Basic read
    do_write(4'd3, 32'h1234_5678);
    do_write(4'd4, 32'h4444_4444);
    drive_rd(1'b1, 4'd3, 1'b1);
    #1;
    check("basic_gnt", 32'(rd_gnt), 32'd1);
    cycle();
    check("basic_valid", 32'(rd_valid), 32'd1);
    check("basic_data", rd_data, 32'h1234_5678);

    // Backpressure; a write to r3 while held must not touch the snapshot
    drive_rd(1'b1, 4'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wr_en   = (i == 0);
      wr_addr = 4'd3;
      wr_data = 32'h0BAD_F00D;
      #1;
      check($sformatf("bp_gnt_%0d", i), 32'(rd_gnt), 32'd0);
      cycle();
      check($sformatf("bp_valid_%0d", i), 32'(rd_valid), 32'd1);
      check($sformatf("bp_data_%0d", i), rd_data, 32'h1234_5678);
    end
    wr_en = 1'b0;
    rd_ready = 1'b1;
    #1;
    check("bp_release_gnt", 32'(rd_gnt), 32'd1);
    cycle();
    check("bp_release_data", rd_data, 32'h4444_4444);

    // Consume without new request -> idle, data retained; ready while idle ignored
    drive_rd(1'b0, 4'd4, 1'b1);
    cycle();
    check("drain_valid", 32'(rd_valid), 32'd0);
    check("drain_data", rd_data, 32'h4444_4444);
    cycle();
    check("idle_ready_valid", 32'(rd_valid), 32'd0);
    check("idle_gnt", 32'(rd_gnt), 32'd0);
    drive_rd(1'b1, 4'd3, 1'b1);
    cycle();
    check("r3_written", rd_data, 32'h0BAD_F00D);

    // Write-through bypass
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hA5A5_A5A5;
    drive_rd(1'b1, 4'd7, 1'b1);
    cycle();
    wr_en = 1'b0;
    check("bypass_data", rd_data, 32'hA5A5_A5A5);
    cycle();
    check("bypass_stored", rd_data, 32'hA5A5_A5A5);

    // Streaming r0..r15, one result per edge
    for (int i = 0; i < 16; i++) do_write(4'(i), 32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 16; i++) begin
      drive_rd(1'b1, 4'(i), 1'b1);
      #1;
      check($sformatf("stream_gnt_%0d", i), 32'(rd_gnt), 32'd1);
      cycle();
      check($sformatf("stream_valid_%0d", i), 32'(rd_valid), 32'd1);
      check($sformatf("stream_data_%0d", i), rd_data, 32'hC0DE_0000 + 32'(i));
    end

    // Register-0 base-address qualifier
    do_write(4'd0, 32'h0000_0040);
    ba_out = 1'b1;
    drive_rd(1'b1, 4'd0, 1'b1);
    cycle();
    check("r0_ba1", rd_data, exp_r0_ba);
    ba_out = 1'b0;
    cycle();
    check("r0_ba0", rd_data, 32'h0000_0040);
    ba_out = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h0000_0077;
    cycle();
    wr_en = 1'b0;
    check("r0_ba1_bypass", rd_data, exp_r0_byp);
    ba_out = 1'b0;
    cycle();
    check("r0_stored", rd_data, 32'h0000_0077);

    drive_rd(1'b0, 4'd0, 1'b1);
    cycle();
    check("final_valid", 32'(rd_valid), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
